ar_arbiter_mux: RTL and testbench
=================================

AR_ARBITER_MUX -- requirements
Module: ar_arbiter_mux

Interface
REQ-001 SHALL take parameter NUM_M, default 4: number of masters, legal 2..8.
REQ-002 SHALL take parameter ADDR_W, default 32: address width.
REQ-003 SHALL take parameter ID_W, default 4: master-side ID width.
REQ-004 SHALL take parameter SEL_W, default 2: width of the slave-decode field.
REQ-005 SHALL take parameter SEL_LSB, default 11: LSB position of the decode field within araddr.
REQ-006 SHALL have one clock and an asynchronous, active-high reset; ports listed below.
REQ-007 SHALL have port aclk, input, 1 bit: clock, all state on rising edge.
REQ-008 SHALL have port areset, input, 1 bit: asynchronous active-high reset.
REQ-009 SHALL have port sel, input, SEL_W bits: this slave's decode value, quasi-static.
REQ-010 SHALL have port araddr_m, input, NUM_M*ADDR_W bits: flattened master addresses, master i at slice i.
REQ-011 SHALL have port arid_m, input, NUM_M*ID_W bits: flattened master IDs.
REQ-012 SHALL have ports arburst_m/arlen_m/arsize_m/arlock_m/arcache_m/arprot_m, input, NUM_M*2/4/3/2/4/3 bits: flattened AR attributes.
REQ-013 SHALL have port arvalid_m, input, NUM_M bits: per-master valid.
REQ-014 SHALL have port arready_m, output, NUM_M bits: per-master ready.
REQ-015 SHALL have ports araddr_s/arburst_s/arlen_s/arsize_s/arlock_s/arcache_s/arprot_s, output, ADDR_W/2/4/3/2/4/3 bits: slave AR payload.
REQ-016 SHALL have port arid_s, output, ID_W+MIDX_W bits (MIDX_W=clog2(NUM_M)): master index concatenated above arid.
REQ-017 SHALL have port arvalid_s, output, 1 bit; and port arready_s, input, 1 bit.

Function
REQ-018 SHALL form req[i] = arvalid_m[i] AND (araddr_m[i][SEL_LSB+SEL_W-1:SEL_LSB] == sel).
REQ-019 SHALL implement FSM with states IDLE and GRANT.
REQ-020 IDLE: when any req is set, SHALL register grant = first i with req[i] searching from rr_ptr upward, mod NUM_M, and enter GRANT next cycle.
REQ-021 IDLE SHALL drive arvalid_s=0 and all arready_m=0.
REQ-022 GRANT SHALL drive the slave payload from the granted master, arvalid_s=req[grant], arready_m[grant]=arready_s, and all other arready_m=0.
REQ-023 GRANT SHALL hold the grant until arvalid_s AND arready_s.
REQ-024 On that handshake, GRANT SHALL set rr_ptr = (grant+1) mod NUM_M and return to IDLE.
REQ-025 Request-to-arvalid_s latency SHALL be 1 cycle; peak throughput SHALL be one transfer per 2 cycles.
REQ-026 If req[grant] drops in GRANT (protocol violation or sel change), SHALL drive arvalid_s=0, stay in GRANT, and issue no arready.
REQ-027 Simultaneous requests SHALL be served round-robin; no master SHALL wait more than NUM_M grants.
REQ-028 Master index SHALL be zero-extended into the top MIDX_W bits of arid_s.

Reset
REQ-029 areset SHALL force: state IDLE, rr_ptr 0, grant 0, arvalid_s 0, arready_m all 0, slice empty.
REQ-030 Reset asserted mid-GRANT SHALL drop arvalid_s immediately (asynchronously) and lose the pending transfer.

Configuration
REQ-031 With macro AR_ARBITER_MUX_REG_SLICE_EN defined, SHALL insert a 2-entry skid buffer between arbiter and slave.
REQ-032 With the slice: arready_m[grant] SHALL equal buffer-not-full; arvalid_s SHALL equal buffer-not-empty.
REQ-033 With the slice: latency SHALL be +1 cycle, no combinational path from arready_s to arready_m, and full throughput under a back-to-back stall.
REQ-034 Without the macro, the slave side SHALL be combinational from the grant per REQ-022.

Structure
REQ-035 Package ax_ic_pkg SHALL hold the AXI field-width constants (burst 2, len 4, size 3, lock 2, cache 4, prot 3), the FSM state enum and a clog2 function.
REQ-036 The skid buffer SHALL be sub-module ar_reg_slice, parametrised on payload width.

Verification (NUM_M=4, SEL_LSB=11, sel=2'b01)
REQ-037 Reset: assert areset with m0 valid -> arvalid_s=0, arready_m=4'b0000 throughout.
REQ-038 Single request: m2 araddr=0x0000_0800, arid=3, arready_s=1 -> arvalid_s at cycle+1, arid_s=6'h23, arready_m=4'b0100 for one cycle.
REQ-039 Decode miss: m1 araddr=0x0000_1000 (field 2'b10) -> arvalid_s stays 0 and m1 is never granted.
REQ-040 Round-robin: all four masters valid and matching -> grant order 0,1,2,3,0, one handshake per 2 cycles.
REQ-041 Backpressure: arready_s=0 for 5 cycles during GRANT -> payload stable and grant held; handshake on the first cycle arready_s=1.
REQ-042 Slice enabled: continuous requests with arready_s toggling 1,0,1 -> no transfer lost or duplicated, arvalid_s latency 2 cycles.

Source files
------------

// File: rtl/ax_ic_pkg.sv
// ----------------------------------------------------------------------------
// ax_ic_pkg
// Shared definitions for the AXI read-address interconnect blocks:
//   - AXI AR attribute field widths (burst, len, size, lock, cache, prot)
//   - arbiter FSM state encoding
//   - clog2 helper used to size master-index fields
// ----------------------------------------------------------------------------
package ax_ic_pkg;

    localparam int BURST_W = 2;
    localparam int LEN_W   = 4;
    localparam int SIZE_W  = 3;
    localparam int LOCK_W  = 2;
    localparam int CACHE_W = 4;
    localparam int PROT_W  = 3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } ar_state_e;

    // Ceiling log2; callers guarantee value >= 2 so the result is never 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 32'sd1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/ar_reg_slice.sv
// ----------------------------------------------------------------------------
// ar_reg_slice
// Two-entry skid buffer for a valid/ready channel. Both handshake signals on
// the input side are derived from the occupancy register only, so there is no
// combinational path from out_ready to in_ready, yet a continuously stalled
// and released sink still sees one transfer per cycle.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   upstream handshake (in_ready = not full)
//   in_data             upstream payload, PAY_W bits
//   out_valid/out_ready downstream handshake (out_valid = not empty)
//   out_data            downstream payload, PAY_W bits
// ----------------------------------------------------------------------------
module ar_reg_slice #(
    parameter int PAY_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PAY_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PAY_W-1:0] out_data
);

    logic [PAY_W-1:0] mem_r [2];
    logic             wr_ptr_r;
    logic             rd_ptr_r;
    logic [1:0]       count_r;
    logic             push_s;
    logic             pop_s;

    assign in_ready  = (count_r != 2'd2);
    assign out_valid = (count_r != 2'd0);
    assign out_data  = mem_r[rd_ptr_r];
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;

    // Occupancy and pointer state; reset empties the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Payload storage; contents are don't-care while the entry is empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

endmodule

// File: rtl/ar_arbiter_mux.sv
// ----------------------------------------------------------------------------
// ar_arbiter_mux
// Round-robin arbiter and multiplexer for the AXI read-address channel of one
// slave. A master requests when its arvalid is set and its address decode
// field equals sel. The IDLE state picks a winner, the GRANT state forwards
// that master's AR beat until the slave accepts it, so one transfer takes two
// cycles. The granted master index is placed above arid on the slave side.
//
// Optional build macro AR_ARBITER_MUX_REG_SLICE_EN inserts a 2-entry skid
// buffer (ar_reg_slice) between the arbiter and the slave port: +1 cycle of
// latency and no combinational arready_s -> arready_m path.
//
// Ports:
//   aclk, areset          clock, asynchronous active-high reset
//   sel                   this slave's decode value (quasi-static)
//   ar*_m                 flattened master AR channels, master i at slice i
//   arvalid_m/arready_m   per-master handshake
//   ar*_s                 slave AR payload; arid_s = {master index, arid}
//   arvalid_s/arready_s   slave handshake
// ----------------------------------------------------------------------------
module ar_arbiter_mux
    import ax_ic_pkg::*;
#(
    parameter  int NUM_M   = 4,
    parameter  int ADDR_W  = 32,
    parameter  int ID_W    = 4,
    parameter  int SEL_W   = 2,
    parameter  int SEL_LSB = 11,
    localparam int MIDX_W  = clog2(NUM_M)
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [SEL_W-1:0]          sel,
    input  logic [NUM_M*ADDR_W-1:0]   araddr_m,
    input  logic [NUM_M*ID_W-1:0]     arid_m,
    input  logic [NUM_M*BURST_W-1:0]  arburst_m,
    input  logic [NUM_M*LEN_W-1:0]    arlen_m,
    input  logic [NUM_M*SIZE_W-1:0]   arsize_m,
    input  logic [NUM_M*LOCK_W-1:0]   arlock_m,
    input  logic [NUM_M*CACHE_W-1:0]  arcache_m,
    input  logic [NUM_M*PROT_W-1:0]   arprot_m,
    input  logic [NUM_M-1:0]          arvalid_m,
    output logic [NUM_M-1:0]          arready_m,
    output logic [ADDR_W-1:0]         araddr_s,
    output logic [ID_W+MIDX_W-1:0]    arid_s,
    output logic [BURST_W-1:0]        arburst_s,
    output logic [LEN_W-1:0]          arlen_s,
    output logic [SIZE_W-1:0]         arsize_s,
    output logic [LOCK_W-1:0]         arlock_s,
    output logic [CACHE_W-1:0]        arcache_s,
    output logic [PROT_W-1:0]         arprot_s,
    output logic                      arvalid_s,
    input  logic                      arready_s
);

    localparam int PAY_W = MIDX_W + ID_W + ADDR_W + BURST_W + LEN_W
                         + SIZE_W + LOCK_W + CACHE_W + PROT_W;

    ar_state_e         state_r, state_nxt_s;
    logic [MIDX_W-1:0] grant_r, grant_nxt_s;
    logic [MIDX_W-1:0] rr_ptr_r, rr_ptr_nxt_s;
    logic [NUM_M-1:0]  req_s;
    logic [MIDX_W-1:0] pick_s;
    logic              in_valid_s;
    logic              in_ready_s;
    logic              push_s;
    logic [PAY_W-1:0]  in_pay_s;
    logic [PAY_W-1:0]  out_pay_s;

    // Per-master request: valid and address decode hits this slave.
    always_comb begin
        req_s = '0;
        for (int i = 0; i < NUM_M; i++) begin
            req_s[i] = arvalid_m[i] && (araddr_m[i*ADDR_W + SEL_LSB +: SEL_W] == sel);
        end
    end

    // Round-robin pick: scan downward so the lowest offset from rr_ptr wins.
    always_comb begin
        logic [MIDX_W-1:0] idx_v;
        pick_s = '0;
        idx_v  = '0;
        for (int k = NUM_M - 1; k >= 0; k--) begin
            idx_v  = MIDX_W'((int'(rr_ptr_r) + k) % NUM_M);
            pick_s = req_s[idx_v] ? idx_v : pick_s;
        end
    end

    // Granted request towards the slave side; a dropped request silences it.
    assign in_valid_s = (state_r == ST_GRANT) && req_s[grant_r];
    assign push_s     = in_valid_s && in_ready_s;

    // Payload mux from the granted master, index prepended to the ID.
    always_comb begin
        in_pay_s = '0;
        for (int i = 0; i < NUM_M; i++) begin
            in_pay_s = in_pay_s | ({PAY_W{grant_r == MIDX_W'(i)}} &
                {MIDX_W'(i),
                 arid_m[i*ID_W +: ID_W],
                 araddr_m[i*ADDR_W +: ADDR_W],
                 arburst_m[i*BURST_W +: BURST_W],
                 arlen_m[i*LEN_W +: LEN_W],
                 arsize_m[i*SIZE_W +: SIZE_W],
                 arlock_m[i*LOCK_W +: LOCK_W],
                 arcache_m[i*CACHE_W +: CACHE_W],
                 arprot_m[i*PROT_W +: PROT_W]});
        end
    end

    // Only the granted master sees ready, and only when its beat is taken.
    always_comb begin
        arready_m = '0;
        for (int i = 0; i < NUM_M; i++) begin
            arready_m[i] = push_s && (grant_r == MIDX_W'(i));
        end
    end

    // FSM next-state: IDLE picks a winner, GRANT waits for acceptance.
    always_comb begin
        state_nxt_s  = state_r;
        grant_nxt_s  = grant_r;
        rr_ptr_nxt_s = rr_ptr_r;
        case (state_r)
            ST_IDLE: begin
                if (|req_s) begin
                    grant_nxt_s = pick_s;
                    state_nxt_s = ST_GRANT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (push_s) begin
                    rr_ptr_nxt_s = (grant_r == MIDX_W'(NUM_M - 1)) ? '0
                                                                   : grant_r + MIDX_W'(1);
                    state_nxt_s  = ST_IDLE;
                end else begin
                    state_nxt_s = ST_GRANT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, grant and round-robin pointer registers.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_r  <= ST_IDLE;
            grant_r  <= '0;
            rr_ptr_r <= '0;
        end else begin
            state_r  <= state_nxt_s;
            grant_r  <= grant_nxt_s;
            rr_ptr_r <= rr_ptr_nxt_s;
        end
    end

`ifdef AR_ARBITER_MUX_REG_SLICE_EN
    ar_reg_slice #(
        .PAY_W (PAY_W)
    ) u_slice (
        .clk       (aclk),
        .rst       (areset),
        .in_valid  (in_valid_s),
        .in_ready  (in_ready_s),
        .in_data   (in_pay_s),
        .out_valid (arvalid_s),
        .out_ready (arready_s),
        .out_data  (out_pay_s)
    );
`else
    assign in_ready_s = arready_s;
    assign arvalid_s  = in_valid_s;
    assign out_pay_s  = in_pay_s;
`endif

    assign {arid_s, araddr_s, arburst_s, arlen_s, arsize_s,
            arlock_s, arcache_s, arprot_s} = out_pay_s;

endmodule

// File: tb/tb_ar_arbiter_mux.sv
// ----------------------------------------------------------------------------
// tb_ar_arbiter_mux
// Scoreboard bench for ar_arbiter_mux (NUM_M=4, SEL_LSB=11, sel=2'b01).
// Expected slave beats are queued when master stimulus is set up and compared
// as the slave-side handshakes occur.
// ----------------------------------------------------------------------------
module tb_ar_arbiter_mux;

`ifdef AR_ARBITER_MUX_REG_SLICE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [5:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
    } exp_t;

    logic         aclk = 1'b0;
    logic         areset = 1'b1;
    logic [1:0]   sel = 2'b01;
    logic [127:0] araddr_m = '0;
    logic [15:0]  arid_m = '0;
    logic [7:0]   arburst_m = '0;
    logic [15:0]  arlen_m = '0;
    logic [11:0]  arsize_m = '0;
    logic [7:0]   arlock_m = '0;
    logic [15:0]  arcache_m = '0;
    logic [11:0]  arprot_m = '0;
    logic [3:0]   arvalid_m = '0;
    logic [3:0]   arready_m;
    logic [31:0]  araddr_s;
    logic [5:0]   arid_s;
    logic [1:0]   arburst_s;
    logic [3:0]   arlen_s;
    logic [2:0]   arsize_s;
    logic [1:0]   arlock_s;
    logic [3:0]   arcache_s;
    logic [2:0]   arprot_s;
    logic         arvalid_s;
    logic         arready_s = 1'b1;

    ar_arbiter_mux dut (
        .aclk(aclk), .areset(areset), .sel(sel),
        .araddr_m(araddr_m), .arid_m(arid_m), .arburst_m(arburst_m),
        .arlen_m(arlen_m), .arsize_m(arsize_m), .arlock_m(arlock_m),
        .arcache_m(arcache_m), .arprot_m(arprot_m),
        .arvalid_m(arvalid_m), .arready_m(arready_m),
        .araddr_s(araddr_s), .arid_s(arid_s), .arburst_s(arburst_s),
        .arlen_s(arlen_s), .arsize_s(arsize_s), .arlock_s(arlock_s),
        .arcache_s(arcache_s), .arprot_s(arprot_s),
        .arvalid_s(arvalid_s), .arready_s(arready_s)
    );

    always #5 aclk = ~aclk;

    int          n_total = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          pops = 0;
    int          last_hs = -1;
    bit          gap_chk = 1'b0;
    exp_t        exp_q[$];
    logic [31:0] m_addr[4];
    logic [3:0]  m_id[4];
    int          m_cnt[4];
    logic        s_vs;
    logic [3:0]  s_rm;
    logic [31:0] s_addr;
    logic [5:0]  s_id;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int m, input logic [3:0] id);
        exp_t e;
        e.id   = {2'(m), id};
        e.addr = m_addr[m];
        e.len  = 4'(m + 1);
        exp_q.push_back(e);
    endtask

    task automatic drive_m();
        for (int i = 0; i < 4; i++) begin
            arvalid_m[i]          = (m_cnt[i] != 0);
            araddr_m[i*32 +: 32]  = m_addr[i];
            arid_m[i*4 +: 4]      = m_id[i];
            arburst_m[i*2 +: 2]   = 2'(i);
            arlen_m[i*4 +: 4]     = 4'(i + 1);
            arsize_m[i*3 +: 3]    = 3'(i);
            arlock_m[i*2 +: 2]    = 2'(i);
            arcache_m[i*4 +: 4]   = 4'(i);
            arprot_m[i*3 +: 3]    = 3'(i);
        end
    endtask

    // One cycle: sample/score at negedge, advance masters just after posedge.
    task automatic tick();
        logic [3:0] hs;
        exp_t       e;
        @(negedge aclk);
        cyc++;
        s_vs   = arvalid_s;
        s_rm   = arready_m;
        s_addr = araddr_s;
        s_id   = arid_s;
        hs     = arready_m & arvalid_m;
        check_val("rdy_onehot", 64'($countones(arready_m) <= 1), 64'd1);
        if (arvalid_s && arready_s) begin
            pops++;
            check_val("xfer_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_val("arid_s", 64'(arid_s), 64'(e.id));
                check_val("araddr_s", 64'(araddr_s), 64'(e.addr));
                check_val("arlen_s", 64'(arlen_s), 64'(e.len));
            end
            if (gap_chk && last_hs >= 0) begin
                check_val("hs_gap", 64'(cyc - last_hs), 64'd2);
            end
            last_hs = cyc;
        end
        @(posedge aclk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (hs[i]) begin
                m_cnt[i] = m_cnt[i] - 1;
                m_id[i]  = m_id[i] + 4'd8;
            end
        end
        drive_m();
    endtask

    task automatic do_reset();
        areset = 1'b1;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        drive_m();
        exp_q.delete();
        tick();
        tick();
        areset = 1'b0;
    endtask

    initial begin
        int p0;
        for (int i = 0; i < 4; i++) begin
            m_addr[i] = 32'h0000_0800 | (32'(i) << 20);
            m_id[i]   = 4'(i);
            m_cnt[i]  = 0;
        end
        drive_m();

        // Reset held with m0 requesting: slave side stays silent.
        m_cnt[0] = 1;
        drive_m();
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val("rst_arvalid_s", 64'(s_vs), 64'd0);
            check_val("rst_arready_m", 64'(s_rm), 64'd0);
        end
        m_cnt[0] = 0;
        drive_m();
        tick();
        areset = 1'b0;

        // Single request from m2, id 3.
        arready_s = 1'b1;
        m_addr[2] = 32'h0000_0800;
        m_id[2]   = 4'd3;
        m_cnt[2]  = 1;
        push_exp(2, 4'd3);
        drive_m();
        tick();
        check_val("single_lat0", 64'(s_vs), 64'd0);
        tick();
        check_val("single_rdy", 64'(s_rm), 64'b0100);
        for (int k = 0; k < LAT - 1; k++) tick();
        check_val("single_vld", 64'(s_vs), 64'd1);
        check_val("single_id", 64'(s_id), 64'h23);
        check_val("single_done", 64'(exp_q.size()), 64'd0);
        tick();
        check_val("single_rdy_once", 64'(s_rm), 64'b0000);

        // Decode miss: m1 addresses field 2'b10.
        m_addr[1] = 32'h0000_1000;
        m_cnt[1]  = 1;
        drive_m();
        for (int k = 0; k < 6; k++) begin
            tick();
            check_val("miss_vld", 64'(s_vs), 64'd0);
            check_val("miss_rdy", 64'(s_rm[1]), 64'd0);
        end
        m_cnt[1] = 0;
        drive_m();
        tick();

        // Backpressure on m3.
        arready_s = 1'b0;
        m_addr[3] = 32'h1234_E804;
        m_id[3]   = 4'd5;
        m_cnt[3]  = 1;
        push_exp(3, 4'd5);
        drive_m();
        tick();
        for (int k = 0; k < LAT; k++) tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            check_val("bp_vld", 64'(s_vs), 64'd1);
            check_val("bp_addr", 64'(s_addr), 64'h1234_E804);
            check_val("bp_id", 64'(s_id), 64'h35);
            check_val("bp_rdy", 64'(s_rm), 64'd0);
        end
        arready_s = 1'b1;
        p0 = pops;
        tick();
        check_val("bp_hs", 64'(pops - p0), 64'd1);
        check_val("bp_done", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of a pending transfer.
        arready_s = 1'b0;
        m_addr[1] = 32'h0000_0800;
        m_id[1]   = 4'd7;
        m_cnt[1]  = 1;
        push_exp(1, 4'd7);
        drive_m();
        tick();
        for (int k = 0; k < LAT; k++) tick();
        check_val("rstmid_pre", 64'(s_vs), 64'd1);
        areset = 1'b1;
        #1;
        check_val("rstmid_async", 64'(arvalid_s), 64'd0);
        check_val("rstmid_rdy", 64'(arready_m), 64'd0);
        do_reset();
        arready_s = 1'b1;

        // Round-robin with all masters matching: order 0,1,2,3,0.
        for (int i = 0; i < 4; i++) begin
            m_addr[i] = 32'h0000_0800 | (32'(i) << 24);
            m_id[i]   = 4'(i);
        end
        m_cnt[0] = 2; m_cnt[1] = 1; m_cnt[2] = 1; m_cnt[3] = 1;
        for (int i = 0; i < 4; i++) push_exp(i, 4'(i));
        push_exp(0, 4'd8);
        drive_m();
        gap_chk = 1'b1;
        last_hs = -1;
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
        gap_chk = 1'b0;
        check_val("rr_drain", 64'(exp_q.size()), 64'd0);
        for (int k = 0; k < 4; k++) tick();

        // Continuous requests with arready_s toggling.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            m_id[i]  = 4'(i);
            m_cnt[i] = 2;
        end
        for (int i = 0; i < 4; i++) push_exp(i, 4'(i));
        for (int i = 0; i < 4; i++) push_exp(i, 4'(i + 8));
        drive_m();
        arready_s = 1'b1;
        for (int k = 0; k < 80 && exp_q.size() != 0; k++) begin
            tick();
            arready_s = ~arready_s;
        end
        check_val("tog_drain", 64'(exp_q.size()), 64'd0);
        arready_s = 1'b1;
        for (int k = 0; k < 6; k++) tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
